taillight_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the taillight controller.
- Synchronises and debounces the five raw driver switches (left, right, hazard, brake, runlights), then resolves conflicting turn requests.
- Its registered outputs drive the controller's left_i/right_i/hazard_i/brake_i/runlights_i inputs.
- Emits a one-cycle change strobe whenever any conditioned output changes.

---
 rtl/taillight_input_conditioner.sv | 102 ++++++++++
 tb/tb_taillight_input_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/taillight_input_conditioner.sv
// Synchronises, debounces and conflict-resolves the five raw taillight switches.
// Outputs are registered from the debounced state; change_o pulses on any output update.
module taillight_input_conditioner #(
  parameter int TICK_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic left_raw_i,
  input  logic right_raw_i,
  input  logic hazard_raw_i,
  input  logic brake_raw_i,
  input  logic runlights_raw_i,
  output logic left_o,
  output logic right_o,
  output logic hazard_o,
  output logic brake_o,
  output logic runlights_o,
  output logic change_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE_CYCLES);

  // Channel index: 0 left, 1 right, 2 hazard, 3 brake, 4 runlights.
  logic [4:0]    raw;
  logic [4:0]    s1;
  logic [4:0]    s2;
  logic [4:0]    db;
  logic [CW-1:0] cnt [5];
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          both;
  logic [4:0]    nxt;
  logic [4:0]    out_q;

  assign raw  = {runlights_raw_i, brake_raw_i, hazard_raw_i, right_raw_i, left_raw_i};
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      pre_cnt <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst) begin
        db[i]  <= 1'b0;
        cnt[i] <= '0;
      end else if (tick) begin
        if (s2[i] != db[i]) begin
          // Flip on the tick that completes the run, restarting the count.
          if (cnt[i] + CW'(1) == DB_TARGET) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Left+right together is treated as a hazard request; hazard overrides turns.
  always_comb begin
    both   = db[0] & db[1];
    nxt    = '0;
    nxt[0] = db[0] & ~both & ~db[2];
    nxt[1] = db[1] & ~both & ~db[2];
    nxt[2] = db[2] | both;
    nxt[3] = db[3];
    nxt[4] = db[4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      change_o <= 1'b0;
    end else begin
      out_q    <= nxt;
      change_o <= (nxt != out_q);
    end
  end

  assign left_o      = out_q[0];
  assign right_o     = out_q[1];
  assign hazard_o    = out_q[2];
  assign brake_o     = out_q[3];
  assign runlights_o = out_q[4];

endmodule

// File: tb/tb_taillight_input_conditioner.sv
// Bench for taillight_input_conditioner: vector table plus scoreboard of expected change pulses.
module tb_taillight_input_conditioner;

  logic clk;
  logic rst;
  logic left_raw, right_raw, hazard_raw, brake_raw, run_raw;
  logic left_o, right_o, hazard_o, brake_o, run_o, change_o;
  logic run2, zero2;
  logic left2_o, right2_o, hazard2_o, brake2_o, run2_o, change2_o;

  int edge_cnt  = 0;
  int since_rst = 0;
  int n_checks  = 0;
  int n_fail    = 0;

  // Vector order everywhere in this bench: {left, right, hazard, brake, runlights}.
  typedef struct {
    logic [4:0] raw;
    int         hold;
    logic [4:0] exp;
    bit         chg;
  } vec_t;

  typedef struct {
    int         edge_n;
    logic [4:0] out;
  } sb_t;

  vec_t tbl [12];
  sb_t  sbq [$];

  wire [4:0] out1 = {left_o, right_o, hazard_o, brake_o, run_o};

  taillight_input_conditioner #(.TICK_DIV(1), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .left_raw_i(left_raw), .right_raw_i(right_raw), .hazard_raw_i(hazard_raw),
    .brake_raw_i(brake_raw), .runlights_raw_i(run_raw),
    .left_o(left_o), .right_o(right_o), .hazard_o(hazard_o),
    .brake_o(brake_o), .runlights_o(run_o), .change_o(change_o)
  );

  taillight_input_conditioner #(.TICK_DIV(4), .DEBOUNCE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .left_raw_i(zero2), .right_raw_i(zero2), .hazard_raw_i(zero2),
    .brake_raw_i(zero2), .runlights_raw_i(run2),
    .left_o(left2_o), .right_o(right2_o), .hazard_o(hazard2_o),
    .brake_o(brake2_o), .runlights_o(run2_o), .change_o(change2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_cnt  <= edge_cnt + 1;
    since_rst <= rst ? 0 : since_rst + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] v);
    {left_raw, right_raw, hazard_raw, brake_raw, run_raw} = v;
  endtask

  // Raw change driven now is sampled on the next edge; outputs follow 6 edges later.
  task automatic expect_change(input logic [4:0] v);
    sb_t e;
    e.edge_n = edge_cnt + 7;
    e.out    = v;
    sbq.push_back(e);
  endtask

  initial begin
    int n0, t, exp_lat, lat;
    bit seen;
    logic val;

    tbl[0]  = '{5'b00000, 10, 5'b00000, 1'b1};
    tbl[1]  = '{5'b00010, 10, 5'b00010, 1'b1};
    tbl[2]  = '{5'b00000, 10, 5'b00000, 1'b1};
    tbl[3]  = '{5'b10000, 10, 5'b10000, 1'b1};
    tbl[4]  = '{5'b11000, 10, 5'b00100, 1'b1};
    tbl[5]  = '{5'b10000, 10, 5'b10000, 1'b1};
    tbl[6]  = '{5'b10100, 10, 5'b00100, 1'b1};
    tbl[7]  = '{5'b11100, 10, 5'b00100, 1'b0};
    tbl[8]  = '{5'b01101, 10, 5'b00101, 1'b1};
    tbl[9]  = '{5'b01001, 10, 5'b01001, 1'b1};
    tbl[10] = '{5'b00000, 10, 5'b00000, 1'b1};
    tbl[11] = '{5'b00000, 10, 5'b00000, 1'b0};

    rst   = 1'b1;
    run2  = 1'b0;
    zero2 = 1'b0;
    drive(5'b11111);
    step(3);
    chk("reset_outputs", {27'd0, out1}, 32'd0);
    chk("reset_change", {31'd0, change_o}, 32'd0);
    chk("reset_outputs_dut2", {27'd0, left2_o, right2_o, hazard2_o, brake2_o, run2_o}, 32'd0);

    fork
      forever begin
        @(negedge clk);
        if (change_o === 1'b1) begin
          if (sbq.size() == 0) begin
            chk("unexpected_change_pulse", 32'd1, 32'd0);
          end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("change_edge", edge_cnt, e.edge_n);
            chk("change_outputs", {27'd0, out1}, {27'd0, e.out});
          end
        end
      end
    join_none

    // Raw inputs held high through reset release must re-qualify from zero.
    rst = 1'b0;
    expect_change(5'b00111);
    step(10);
    chk("release_outputs", {27'd0, out1}, {27'd0, 5'b00111});

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].raw);
      if (tbl[i].chg) expect_change(tbl[i].exp);
      step(tbl[i].hold);
      chk($sformatf("table_row_%0d", i), {27'd0, out1}, {27'd0, tbl[i].exp});
    end

    // Three-cycle brake glitch must be filtered.
    drive(5'b00010);
    step(3);
    drive(5'b00000);
    step(12);
    chk("glitch_filtered", {27'd0, out1}, 32'd0);

    // Bouncing left switch settles high.
    for (int i = 0; i < 4; i++) begin
      drive((i % 2 == 0) ? 5'b10000 : 5'b00000);
      step(1);
    end
    drive(5'b10000);
    expect_change(5'b10000);
    step(10);
    chk("bounce_settled", {27'd0, out1}, {27'd0, 5'b10000});
    drive(5'b00000);
    expect_change(5'b00000);
    step(10);

    // Hazard count reaches 3 of 4, then a single reset edge clears it.
    drive(5'b00100);
    step(5);
    rst = 1'b1;
    step(1);
    chk("midreset_outputs", {27'd0, out1}, 32'd0);
    rst = 1'b0;
    expect_change(5'b00100);
    step(6);
    chk("midreset_not_yet", {31'd0, hazard_o}, 32'd0);
    step(4);
    chk("midreset_requalified", {27'd0, out1}, {27'd0, 5'b00100});
    drive(5'b00000);
    expect_change(5'b00000);
    step(10);

    // Prescaled instance: tick edges are every 4th edge counted from reset release.
    for (int p = 0; p < 3; p++) begin
      step(p + 1);
      n0      = since_rst;
      val     = (p % 2 == 0);
      run2    = val;
      t       = ((n0 + 6) / 4) * 4;
      exp_lat = t + 5 - n0;
      seen    = 1'b0;
      lat     = 0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk);
        #1;
        if (run2_o == val) begin
          seen = 1'b1;
          lat  = since_rst - n0;
          break;
        end
      end
      chk($sformatf("presc_seen_%0d", p), {31'd0, seen}, 32'd1);
      if (seen) begin
        chk($sformatf("presc_latency_%0d", p), lat, exp_lat);
        chk($sformatf("presc_window_%0d", p), {31'd0, (lat >= 8 && lat <= 12)}, 32'd1);
        chk($sformatf("presc_change_%0d", p), {31'd0, change2_o}, 32'd1);
      end
      step(2);
    end

    step(10);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
